// File: rtl/dfi_init_seq_pkg.sv
// Shared types and defaults for the DFI init handshake sequencer.
package dfi_init_seq_pkg;

  localparam int unsigned DefCntW     = 16;
  localparam int unsigned DefInitCntW = 8;

  // Encodings are visible to software through state_o.
  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StWaitRdy = 3'd1,
    StDelay   = 3'd2,
    StDone    = 3'd3,
    StErr     = 3'd4
  } state_e;

endpackage

// File: rtl/prim_flop_2sync.sv
// Generic two-flop synchronizer with a programmable reset value.
module prim_flop_2sync #(
  parameter int unsigned      Width      = 1,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;

  // Two back-to-back stages to settle metastability.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= ResetValue;
      q_o    <= ResetValue;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

// File: rtl/dfi_init_seq.sv
// DFI initialization handshake sequencer: waits for readiness, applies a
// settle delay, raises done, and flags a timeout if readiness never comes.
// Build option: define DFI_INIT_SEQ_SYNC_EN to pass dfi_init_start_i and
// phy_ready_i through 2-flop synchronizers (adds 2 edges of latency).
module dfi_init_seq
  import dfi_init_seq_pkg::*;
#(
  parameter int unsigned CntW     = DefCntW,
  parameter int unsigned InitCntW = DefInitCntW
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                dfi_init_start_i,
  output logic                dfi_init_done_o,
  input  logic                phy_ready_i,
  input  logic                sw_mode_i,
  input  logic                sw_done_i,
  input  logic [CntW-1:0]     cfg_delay_i,
  input  logic [CntW-1:0]     cfg_timeout_i,
  input  logic                clr_i,
  output logic                busy_o,
  output logic                timeout_o,
  output logic [2:0]          state_o,
  output logic [InitCntW-1:0] init_cnt_o
);

  logic start;
  logic phy_rdy;
  logic rdy;

`ifdef DFI_INIT_SEQ_SYNC_EN
  prim_flop_2sync #(
    .Width      (2),
    .ResetValue (2'b00)
  ) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    ({dfi_init_start_i, phy_ready_i}),
    .q_o    ({start, phy_rdy})
  );
`else
  assign start   = dfi_init_start_i;
  assign phy_rdy = phy_ready_i;
`endif

  assign rdy = sw_mode_i ? sw_done_i : phy_rdy;

  state_e              state_q, state_d;
  logic [CntW-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic [CntW-1:0]     dly_cnt_q, dly_cnt_d;
  logic                timeout_q, timeout_d;
  logic [InitCntW-1:0] init_cnt_q, init_cnt_d;

  // State and counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      tmo_cnt_q  <= '0;
      dly_cnt_q  <= '0;
      timeout_q  <= 1'b0;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      tmo_cnt_q  <= tmo_cnt_d;
      dly_cnt_q  <= dly_cnt_d;
      timeout_q  <= timeout_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // Next-state, counter loads/decrements and sticky flag updates.
  always_comb begin
    state_d    = state_q;
    tmo_cnt_d  = tmo_cnt_q;
    dly_cnt_d  = dly_cnt_q;
    timeout_d  = timeout_q;
    init_cnt_d = init_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StWaitRdy;
          tmo_cnt_d = cfg_timeout_i;
        end
      end

      StWaitRdy: begin
        if (!start) begin
          state_d = StIdle;
        end else if (rdy && (cfg_delay_i == '0)) begin
          state_d = StDone;
        end else if (rdy) begin
          state_d   = StDelay;
          dly_cnt_d = cfg_delay_i - CntW'(1);
        end else if (tmo_cnt_q == CntW'(1)) begin
          // A disabled timeout loads 0 and never reaches 1, so the loaded
          // count alone decides; mid-wait edits of cfg_timeout_i are ignored.
          state_d   = StErr;
          timeout_d = 1'b1;
        end else if (tmo_cnt_q != '0) begin
          tmo_cnt_d = tmo_cnt_q - CntW'(1);
        end
      end

      StDelay: begin
        if (!start) begin
          state_d = StIdle;
        end else if (dly_cnt_q == '0) begin
          state_d = StDone;
        end else begin
          dly_cnt_d = dly_cnt_q - CntW'(1);
        end
      end

      StDone: begin
        if (!start) begin
          state_d = StIdle;
          if (init_cnt_q != '1) begin
            init_cnt_d = init_cnt_q + InitCntW'(1);
          end
        end
      end

      StErr: begin
        if (clr_i) begin
          state_d   = StIdle;
          timeout_d = 1'b0;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign dfi_init_done_o = (state_q == StDone);
  assign busy_o          = (state_q == StWaitRdy) || (state_q == StDelay);
  assign timeout_o       = timeout_q;
  assign state_o         = state_q;
  assign init_cnt_o      = init_cnt_q;

endmodule

// File: tb/tb_dfi_init_seq.sv
// Self-checking bench for dfi_init_seq: directed handshake, randomized
// transactions predicted from event times, counter saturation, async reset.
module tb_dfi_init_seq;

  localparam int unsigned CntW     = 16;
  localparam int unsigned InitCntW = 8;
  localparam int          None     = 100000;

  logic                clk_i = 1'b0;
  logic                rst_ni;
  logic                dfi_init_start_i;
  logic                dfi_init_done_o;
  logic                phy_ready_i;
  logic                sw_mode_i;
  logic                sw_done_i;
  logic [CntW-1:0]     cfg_delay_i;
  logic [CntW-1:0]     cfg_timeout_i;
  logic                clr_i;
  logic                busy_o;
  logic                timeout_o;
  logic [2:0]          state_o;
  logic [InitCntW-1:0] init_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;
  int model_cnt = 0;

  dfi_init_seq #(
    .CntW     (CntW),
    .InitCntW (InitCntW)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .dfi_init_start_i (dfi_init_start_i),
    .dfi_init_done_o  (dfi_init_done_o),
    .phy_ready_i      (phy_ready_i),
    .sw_mode_i        (sw_mode_i),
    .sw_done_i        (sw_done_i),
    .cfg_delay_i      (cfg_delay_i),
    .cfg_timeout_i    (cfg_timeout_i),
    .clr_i            (clr_i),
    .busy_o           (busy_o),
    .timeout_o        (timeout_o),
    .state_o          (state_o),
    .init_cnt_o       (init_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Every output follows from the expected state and handshake count.
  task automatic expect_all(input string tag, input int st, input int cnt);
    check({tag, ".state"},   32'(state_o), st);
    check({tag, ".done"},    32'(dfi_init_done_o), (st == 3) ? 1 : 0);
    check({tag, ".busy"},    32'(busy_o), (st == 1 || st == 2) ? 1 : 0);
    check({tag, ".timeout"}, 32'(timeout_o), (st == 4) ? 1 : 0);
    check({tag, ".cnt"},     32'(init_cnt_o), cnt);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic void bump_cnt();
    if (model_cnt < 255) model_cnt++;
  endfunction

  // Expected state k edges after WAIT_RDY entry, from the event times.
  function automatic int exp_state(input int k, input int r, input int t_done,
                                   input int t_err, input int a, input bit aborted);
    if (aborted) return (k >= a) ? 0 : ((k >= r) ? 2 : 1);
    if (t_err != None) return (k >= t_err + 2) ? 0 : ((k >= t_err) ? 4 : 1);
    if (k < r)      return 1;
    if (k < t_done) return 2;
    if (k < a)      return 3;
    return 0;
  endfunction

  task automatic run_txn(input int idx);
    int  d, t, r, a, t_done, t_err, last, first_evt;
    bit  mode, rdy_ok, aborted, rv;
    string tag;
    tag    = $sformatf("txn%0d", idx);
    mode   = 1'($urandom_range(0, 1));
    d      = $urandom_range(0, 6);
    t      = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 15);
    r      = ($urandom_range(0, 3) == 0) ? None : $urandom_range(1, 20);
    a      = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 25) : None;
    rdy_ok = (r != None) && (t == 0 || r <= t);
    t_err  = (!rdy_ok && t != 0) ? t : None;
    t_done = rdy_ok ? r + d : None;
    first_evt = (t_done < t_err) ? t_done : t_err;
    aborted = (a != None) && (a <= first_evt);
    if (!aborted && t_err == None && t_done == None) begin
      a = $urandom_range(1, 25);
      aborted = 1'b1;
    end
    if (!aborted && t_err != None) a = None;
    if (!aborted && t_done != None && a == None) a = t_done + $urandom_range(1, 3);
    last = (!aborted && t_err != None) ? t_err + 2 : a;

    cfg_delay_i      = CntW'(d);
    cfg_timeout_i    = CntW'(t);
    sw_mode_i        = mode;
    sw_done_i        = mode ? 1'b0 : 1'($urandom_range(0, 1));
    phy_ready_i      = mode ? 1'($urandom_range(0, 1)) : 1'b0;
    clr_i            = 1'b0;
    dfi_init_start_i = 1'b1;
    step();
    expect_all({tag, ".k0"}, 1, model_cnt);

    for (int k = 1; k <= last; k++) begin
      dfi_init_start_i = (k < a) ? 1'b1 : 1'b0;
      rv = (r != None && k == r) ? 1'b1 :
           ((r != None && k > r) ? 1'($urandom_range(0, 1)) : 1'b0);
      if (mode) begin
        sw_done_i   = rv;
        phy_ready_i = 1'($urandom_range(0, 1));
      end else begin
        phy_ready_i = rv;
        sw_done_i   = 1'($urandom_range(0, 1));
      end
      cfg_timeout_i = CntW'($urandom_range(1, 65535));
      if (r != None && k > r) cfg_delay_i = CntW'($urandom_range(0, 65535));
      if (t_err != None && k == t_err + 2)
        clr_i = 1'b1;
      else if (exp_state(k - 1, r, t_done, t_err, a, aborted) != 4)
        clr_i = ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0;
      else
        clr_i = 1'b0;
      step();
      if (!aborted && t_done != None && k == a) bump_cnt();
      expect_all($sformatf("%s.k%0d", tag, k),
                 exp_state(k, r, t_done, t_err, a, aborted), model_cnt);
    end
    clr_i = 1'b0;

    // After clearing ERR with start still high, a new attempt starts next edge.
    if (!aborted && t_err != None) begin
      if ($urandom_range(0, 1) == 1) begin
        step();
        expect_all({tag, ".retry"}, 1, model_cnt);
      end
      dfi_init_start_i = 1'b0;
      step();
      expect_all({tag, ".idle"}, 0, model_cnt);
    end
  endtask

  initial begin
    rst_ni           = 1'b0;
    dfi_init_start_i = 1'b0;
    phy_ready_i      = 1'b0;
    sw_mode_i        = 1'b0;
    sw_done_i        = 1'b0;
    cfg_delay_i      = '0;
    cfg_timeout_i    = '0;
    clr_i            = 1'b0;
    #3;
    expect_all("reset", 0, 0);
    #4;
    rst_ni = 1'b1;

    // Directed: HW mode, ready already high, zero delay.
    phy_ready_i      = 1'b1;
    dfi_init_start_i = 1'b1;
`ifdef DFI_INIT_SEQ_SYNC_EN
    step(); expect_all("sync.e1", 0, 0);
    step(); expect_all("sync.e2", 0, 0);
    step(); expect_all("sync.e3", 1, 0);
    step(); expect_all("sync.e4", 3, 0);
    dfi_init_start_i = 1'b0;
    step(); expect_all("sync.e5", 3, 0);
    step(); expect_all("sync.e6", 3, 0);
    step(); expect_all("sync.e7", 0, 1);
`else
    step(); expect_all("dir.e1", 1, 0);
    step(); expect_all("dir.e2", 3, 0);
    dfi_init_start_i = 1'b0;
    step(); bump_cnt(); expect_all("dir.e3", 0, model_cnt);

    for (int i = 0; i < 80; i++) run_txn(i);

    // Saturation: enough full handshakes to pass 255.
    sw_mode_i     = 1'b0;
    phy_ready_i   = 1'b1;
    cfg_delay_i   = '0;
    cfg_timeout_i = '0;
    for (int i = 0; i < 258; i++) begin
      dfi_init_start_i = 1'b1;
      step(); expect_all("sat.wait", 1, model_cnt);
      step(); expect_all("sat.done", 3, model_cnt);
      dfi_init_start_i = 1'b0;
      step(); bump_cnt(); expect_all("sat.idle", 0, model_cnt);
    end
    check("sat.final", 32'(init_cnt_o), 255);

    // Asynchronous reset while in DELAY.
    cfg_delay_i      = CntW'(10);
    dfi_init_start_i = 1'b1;
    step(); expect_all("rst.wait", 1, model_cnt);
    step(); expect_all("rst.delay", 2, model_cnt);
    #2;
    rst_ni = 1'b0;
    #1;
    model_cnt = 0;
    expect_all("rst.async", 0, 0);
    dfi_init_start_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    step(); expect_all("rst.after", 0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
